// File: rtl/hex_line_decoder.sv
// hex_line_decoder
//   Receive side of the inline debug print path. Consumes the ASCII byte stream
//   produced by a "%x\n" display and rebuilds the hex digits of each line into a
//   WIDTH-bit word, presented with error flags over a valid/ready handshake.
//
// Ports
//   CLK           clock, all state changes on the rising edge
//   RESET         synchronous active-high reset, wins over every other event
//   in_data       ASCII byte
//   in_valid      in_data valid
//   in_ready      byte accepted this cycle when in_valid is also high
//   out_data      decoded word (zero while out_valid is low)
//   out_bad_char  line held a byte that is not hex, CR or LF
//   out_overflow  line held more than MAXDIG hex digits
//   out_valid     out_data and flags valid
//   out_ready     consumer accepts the word
module hex_line_decoder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_bad_char,
   output logic             out_overflow,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned MAXDIG = (WIDTH + 3) / 4;
   localparam int unsigned CntW   = $clog2(MAXDIG + 2);

   localparam logic [CntW-1:0] MaxCnt = CntW'(MAXDIG);
   localparam logic [CntW-1:0] SatCnt = CntW'(MAXDIG + 1);

   localparam logic [7:0] AsciiCr = 8'h0D;
   localparam logic [7:0] AsciiLf = 8'h0A;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StEmit
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             bad_q, bad_d;
   logic             ovf_q, ovf_d;

   logic             is_hex;
   logic [3:0]       nib;
   logic [WIDTH+3:0] acc_shift;

   // ASCII hex digit decode.
   always_comb begin
      is_hex = 1'b0;
      nib    = 4'h0;
      if (in_data >= 8'h30 && in_data <= 8'h39) begin
         is_hex = 1'b1;
         nib    = 4'(in_data - 8'h30);
      end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
         is_hex = 1'b1;
         nib    = 4'(in_data - 8'h57);
      end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
         is_hex = 1'b1;
         nib    = 4'(in_data - 8'h37);
      end
   end

   // Oldest digits fall off the top; a partial top digit is truncated.
   assign acc_shift = {acc_q, nib};

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bad_d   = bad_q;
      ovf_d   = ovf_q;

      case (state_q)
         StIdle, StAccum: begin
            if (in_valid) begin
               if (is_hex) begin
                  acc_d = acc_shift[WIDTH-1:0];
                  if (cnt_q != SatCnt) begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (cnt_q >= MaxCnt) begin
                     ovf_d = 1'b1;
                  end
                  state_d = StAccum;
               end else if (in_data == AsciiCr) begin
                  state_d = state_q;
               end else if (in_data == AsciiLf) begin
                  // A blank line in StIdle produces no word.
                  if (state_q == StAccum) begin
                     state_d = StEmit;
                  end
               end else begin
                  bad_d   = 1'b1;
                  state_d = StAccum;
               end
            end
         end
         StEmit: begin
            if (out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               bad_d   = 1'b0;
               ovf_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         bad_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bad_q   <= bad_d;
         ovf_q   <= ovf_d;
      end
   end

   // All outputs come straight from registers; no input-to-output path.
   assign in_ready     = (state_q != StEmit);
   assign out_valid    = (state_q == StEmit);
   assign out_data     = out_valid ? acc_q : '0;
   assign out_bad_char = out_valid & bad_q;
   assign out_overflow = out_valid & ovf_q;

endmodule
